// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side stream adapter for a TDP18K FIFO running in FIFO mode.
// Drives REN with credit-based flow control and captures RDATA after RD_LAT
// cycles into a skid buffer. It also sequences the FIFO flush and latches
// underrun as a sticky error.
// Ports: CLK_i, RST_ni (async, active low), FLUSH_i
//        FIFO_REN_o, FIFO_RDATA_i, FIFO_EMPTY_i, FIFO_UNDERRUN_i, FIFO_FLUSH_no
//        M_VALID_o, M_READY_i, M_DATA_o (stream side), ERR_o (sticky underrun)
// Optional: define FIFO_RD_STREAM_STATS_EN to add WORD_CNT_o / STALL_CNT_o.
module fifo_rd_stream #(
  parameter int DATA_W    = 18,
  parameter int RD_LAT    = 1,
  parameter int BUF_DEPTH = 2
) (
  input  logic              CLK_i,
  input  logic              RST_ni,
  input  logic              FLUSH_i,
  output logic              FIFO_REN_o,
  input  logic [DATA_W-1:0] FIFO_RDATA_i,
  input  logic              FIFO_EMPTY_i,
  input  logic              FIFO_UNDERRUN_i,
  output logic              FIFO_FLUSH_no,
  output logic              M_VALID_o,
  input  logic              M_READY_i,
  output logic [DATA_W-1:0] M_DATA_o,
  output logic              ERR_o
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]       WORD_CNT_o,
  output logic [15:0]       STALL_CNT_o
`endif
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  // Wide enough for count + inflight together.
  localparam int CW = $clog2(BUF_DEPTH + RD_LAT + 1);

  typedef enum logic {
    S_FLUSH,
    S_RUN
  } state_t;

  state_t            r_state;
  logic              r_fcnt;
  logic              r_flush_n;
  logic              r_err;
  logic [RD_LAT-1:0] r_sr;
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_buf [BUF_DEPTH];

  logic              w_pop;
  logic              w_push;
  logic              w_ren;
  logic [CW-1:0]     w_infl;
  logic [CW-1:0]     w_credit;
  logic [RD_LAT-1:0] w_sr_nxt;

  function automatic logic [PW-1:0] f_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign M_VALID_o     = (r_count != '0);
  assign M_DATA_o      = r_buf[r_head];
  assign FIFO_FLUSH_no = r_flush_n;
  assign ERR_o         = r_err;
  assign w_pop         = M_VALID_o && M_READY_i;
  // Marker leaving the shift register means RDATA is valid now.
  assign w_push        = r_sr[RD_LAT-1];

  always_comb begin
    w_infl = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_infl = w_infl + CW'(r_sr[i]);
    end
  end

  // Reserve a buffer slot for every read already issued.
  // A pop this cycle frees one slot, so full throughput holds.
  assign w_credit = r_count + w_infl - CW'(w_pop);

  assign w_ren = (r_state == S_RUN) && !FIFO_EMPTY_i
              && (w_credit < CW'(BUF_DEPTH));

  assign FIFO_REN_o = w_ren;

  always_comb begin
    w_sr_nxt    = r_sr << 1;
    w_sr_nxt[0] = w_ren;
  end

  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      r_state   <= S_FLUSH;
      r_fcnt    <= 1'b0;
      r_flush_n <= 1'b0;
    end else begin
      unique case (r_state)
        S_FLUSH: begin
          if (FLUSH_i) begin
            r_fcnt <= 1'b0;
          end else if (r_fcnt) begin
            r_state   <= S_RUN;
            r_flush_n <= 1'b1;
            r_fcnt    <= 1'b0;
          end else begin
            r_fcnt <= 1'b1;
          end
        end
        S_RUN: begin
          if (FLUSH_i) begin
            r_state   <= S_FLUSH;
            r_flush_n <= 1'b0;
            r_fcnt    <= 1'b0;
          end
        end
      endcase
    end
  end

  // A flush drops everything, including words still in flight.
  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      r_sr    <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (FLUSH_i) begin
      r_sr    <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_sr <= w_sr_nxt;
      if (w_push) begin
        r_buf[r_tail] <= FIFO_RDATA_i;
        r_tail        <= f_inc(r_tail);
      end
      if (w_pop) begin
        r_head <= f_inc(r_head);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      r_err <= 1'b0;
    end else if (FLUSH_i) begin
      r_err <= 1'b0;
    end else if (r_state == S_RUN && FIFO_UNDERRUN_i) begin
      r_err <= 1'b1;
    end
  end

  a_no_push_full : assert property (
    @(posedge CLK_i) disable iff (!RST_ni)
    !(w_push && !w_pop && !FLUSH_i && r_count == CW'(BUF_DEPTH))
  );

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] r_word_cnt;
  logic [15:0] r_stall_cnt;

  assign WORD_CNT_o  = r_word_cnt;
  assign STALL_CNT_o = r_stall_cnt;

  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      r_word_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (FLUSH_i) begin
        r_word_cnt <= '0;
      end else if (w_pop) begin
        r_word_cnt <= r_word_cnt + 32'd1;
      end
      if (M_VALID_o && !M_READY_i && r_stall_cnt != 16'hFFFF) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: cycle-stepped bench with a behavioural TDP18K FIFO model
// and a scoreboard queue of expected stream words.
module tb_fifo_rd_stream;
  localparam int DW = 18;

  logic          CLK_i = 1'b0;
  logic          RST_ni;
  logic          FLUSH_i;
  logic          FIFO_REN_o;
  logic [DW-1:0] FIFO_RDATA_i;
  logic          FIFO_EMPTY_i;
  logic          FIFO_UNDERRUN_i;
  logic          FIFO_FLUSH_no;
  logic          M_VALID_o;
  logic          M_READY_i;
  logic [DW-1:0] M_DATA_o;
  logic          ERR_o;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0]   WORD_CNT_o;
  logic [15:0]   STALL_CNT_o;
`endif

  always #5 CLK_i = ~CLK_i;

  fifo_rd_stream #(
    .DATA_W(DW),
    .RD_LAT(1),
    .BUF_DEPTH(2)
  ) dut (
    .CLK_i(CLK_i),
    .RST_ni(RST_ni),
    .FLUSH_i(FLUSH_i),
    .FIFO_REN_o(FIFO_REN_o),
    .FIFO_RDATA_i(FIFO_RDATA_i),
    .FIFO_EMPTY_i(FIFO_EMPTY_i),
    .FIFO_UNDERRUN_i(FIFO_UNDERRUN_i),
    .FIFO_FLUSH_no(FIFO_FLUSH_no),
    .M_VALID_o(M_VALID_o),
    .M_READY_i(M_READY_i),
    .M_DATA_o(M_DATA_o),
    .ERR_o(ERR_o)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .WORD_CNT_o(WORD_CNT_o),
    .STALL_CNT_o(STALL_CNT_o)
`endif
  );

  // FIFO model: memory with read/write pointers
  logic [DW-1:0] fmem [256];
  logic [7:0]    wp;
  logic [7:0]    rp;
  assign FIFO_EMPTY_i = (rp == wp);

  logic [DW-1:0] stage_q [$];
  logic [DW-1:0] exp_q [$];

  logic rst_g, rdy, flsh, urn;
  logic pend_ren, pend_flush;
  logic s_ren, s_beat, s_flush_n;
  int   cyc, n_vec, n_err, n_stall;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic stage(logic [DW-1:0] v);
    stage_q.push_back(v);
    exp_q.push_back(v);
  endtask

  // One clock: the FIFO reacts to last cycle's REN/flush, inputs are driven,
  // then outputs are sampled mid-cycle.
  task automatic step();
    logic [DW-1:0] e;
    @(negedge CLK_i);
    if (pend_flush) begin
      rp = wp;
    end else if (pend_ren) begin
      FIFO_RDATA_i = fmem[rp];
      rp = rp + 8'd1;
    end
    while (stage_q.size() > 0) begin
      fmem[wp] = stage_q.pop_front();
      wp = wp + 8'd1;
    end
    RST_ni          = rst_g;
    M_READY_i       = rdy;
    FLUSH_i         = flsh;
    FIFO_UNDERRUN_i = urn;
    #1;
    s_ren     = FIFO_REN_o;
    s_flush_n = FIFO_FLUSH_no;
    s_beat    = M_VALID_o && M_READY_i;
    if (M_VALID_o && !M_READY_i) n_stall++;
    if (s_beat) begin
      chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_data", 32'(M_DATA_o), 32'(e));
      end
    end
    pend_ren   = s_ren;
    pend_flush = !s_flush_n;
    cyc++;
  endtask

  int nren, nbeat, fr, lr, fb, lb, lows, chg, seen;
  logic [DW-1:0] held;

  initial begin
    cyc = 0; n_vec = 0; n_err = 0; n_stall = 0;
    rst_g = 0; rdy = 0; flsh = 0; urn = 0;
    pend_ren = 0; pend_flush = 0;
    wp = 0; rp = 0;
    FIFO_RDATA_i = '0; FLUSH_i = 0; M_READY_i = 0; FIFO_UNDERRUN_i = 0;
    RST_ni = 1'b1;
    #1 RST_ni = 1'b0;
    step(); step();
    chk("rst_ren", 32'(FIFO_REN_o), 32'd0);
    chk("rst_flush_n", 32'(FIFO_FLUSH_no), 32'd0);
    chk("rst_valid", 32'(M_VALID_o), 32'd0);
    chk("rst_data", 32'(M_DATA_o), 32'd0);
    chk("rst_err", 32'(ERR_o), 32'd0);

    // Reset release, idle
    rst_g = 1; lows = 0; nren = 0; nbeat = 0;
    repeat (6) begin
      step();
      if (!s_flush_n) lows++;
      if (s_ren) nren++;
      if (M_VALID_o) nbeat++;
    end
    chk("idle_flush_low", 32'(lows), 32'd2);
    chk("idle_ren", 32'(nren), 32'd0);
    chk("idle_valid", 32'(nbeat), 32'd0);

    // Streaming
    rdy = 1;
    for (int i = 1; i <= 8; i++) stage(DW'(i));
    nren = 0; nbeat = 0; fr = -1; lr = -1; fb = -1; lb = -1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (s_ren) begin
        if (fr < 0) fr = cyc;
        lr = cyc; nren++;
      end
      if (s_beat) begin
        if (fb < 0) fb = cyc;
        lb = cyc; nbeat++;
      end
    end
    chk("st_ren_n", 32'(nren), 32'd8);
    chk("st_ren_span", 32'(lr - fr), 32'd7);
    chk("st_beat_n", 32'(nbeat), 32'd8);
    chk("st_beat_span", 32'(lb - fb), 32'd7);
    chk("st_latency", 32'(fb - fr), 32'd2);
    chk("st_sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef FIFO_RD_STREAM_STATS_EN
    chk("word_cnt", WORD_CNT_o, 32'd8);
`endif

    // Backpressure
    rdy = 0;
    for (int i = 1; i <= 8; i++) stage(DW'(i));
    nren = 0; chg = 0; seen = 0; held = '0;
    repeat (10) begin
      step();
      if (s_ren) nren++;
      if (M_VALID_o) begin
        if (seen != 0 && M_DATA_o != held) chg++;
        held = M_DATA_o; seen = 1;
      end
    end
    chk("bp_ren_n", 32'(nren), 32'd2);
    chk("bp_valid", 32'(M_VALID_o), 32'd1);
    chk("bp_head", 32'(M_DATA_o), 32'd1);
    chk("bp_stable", 32'(chg), 32'd0);
    rdy = 1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      step();
      if (s_ren) nren++;
    end
    chk("bp_ren_total", 32'(nren), 32'd8);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
`ifdef FIFO_RD_STREAM_STATS_EN
    chk("stall_cnt", 32'(STALL_CNT_o), 32'(n_stall));
`endif

    // Empty boundary
    repeat (3) step();
    stage(DW'(1));
    nren = 0; nbeat = 0;
    repeat (8) begin
      step();
      if (s_ren) nren++;
      if (s_beat) nbeat++;
    end
    chk("eb_ren_n", 32'(nren), 32'd1);
    chk("eb_beat_n", 32'(nbeat), 32'd1);
    chk("eb_sb_empty", 32'(exp_q.size()), 32'd0);

    // Flush with a word in flight
    stage(DW'(18'h11));
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      step();
      if (s_ren) seen = 1;
    end
    chk("fl_ren_seen", 32'(seen), 32'd1);
    flsh = 1;
    step();
    flsh = 0;
    exp_q.delete();
    step();
    chk("fl_valid", 32'(M_VALID_o), 32'd0);
    chk("fl_fn_c0", 32'(s_flush_n), 32'd0);
    step();
    chk("fl_fn_c1", 32'(s_flush_n), 32'd0);
    chk("fl_ren_off", 32'(s_ren), 32'd0);
    step();
    chk("fl_fn_c2", 32'(s_flush_n), 32'd1);
    stage(DW'(18'h22));
    nbeat = 0;
    repeat (10) begin
      step();
      if (s_beat) nbeat++;
    end
    chk("fl_resume", 32'(nbeat), 32'd1);
    chk("fl_sb_empty", 32'(exp_q.size()), 32'd0);

    // Underrun
    chk("ur_err_pre", 32'(ERR_o), 32'd0);
    urn = 1;
    step();
    urn = 0;
    step();
    chk("ur_err_set", 32'(ERR_o), 32'd1);
    repeat (3) step();
    chk("ur_err_hold", 32'(ERR_o), 32'd1);
    flsh = 1;
    step();
    flsh = 0;
    step();
    chk("ur_err_clr", 32'(ERR_o), 32'd0);
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side adapter that sits directly downstream of the TDP18K FIFO primitive when it runs in FIFO mode (FMODE_i=1).
- Drives the primitive's read enable, captures read data that returns with fixed latency, and presents it as a valid/ready stream with full throughput.
- Handles flush sequencing, discards read data that is still in flight when a flush occurs, and latches FIFO underrun as a sticky error.
- Single clock domain: the FIFO is used in synchronous mode, and the FIFO's CLK_B_i is tied to CLK_i.

Parameters:
- DATA_W, 18, width of the read data bus (1..18).
- RD_LAT, 1, cycles from FIFO_REN_o high to the matching FIFO_RDATA_i being valid (1..2).
- BUF_DEPTH, 2, output skid buffer entries; must be >= RD_LAT+1 for full throughput.

Ports:
- CLK_i  input  1  single clock; the FIFO's CLK_B_i is tied to this clock.
- RST_ni  input  1  asynchronous, active-low reset.
- FLUSH_i  input  1  synchronous flush request, active high.
- FIFO_REN_o  output  1  to the FIFO REN_B_i.
- FIFO_RDATA_i  input  DATA_W  from the FIFO RDATA_B_o.
- FIFO_EMPTY_i  input  1  from the FIFO EMPTY_o.
- FIFO_UNDERRUN_i  input  1  from the FIFO UNDERRUN_o.
- FIFO_FLUSH_no  output  1  to the FIFO FLUSH_ni, active low.
- M_VALID_o  output  1  stream valid.
- M_READY_i  input  1  stream ready.
- M_DATA_o  output  DATA_W  stream data, taken from the buffer head.
- ERR_o  output  1  sticky underrun flag.

Behaviour:
- Reset values:
  - FIFO_REN_o=0, FIFO_FLUSH_no=0 (the FIFO is held in flush during reset).
  - M_VALID_o=0, M_DATA_o=0, ERR_o=0.
  - Buffer count=0, in-flight count=0, state=FLUSH.
- State machine: FLUSH -> RUN.
  - FLUSH: FIFO_FLUSH_no=0 for exactly 2 cycles (counter), then go to RUN with FIFO_FLUSH_no=1.
  - RUN -> FLUSH when FLUSH_i=1 is sampled.
  - Reset released mid-operation always enters FLUSH.
- Read issue (RUN only):
  - FIFO_REN_o = !FIFO_EMPTY_i && (count + inflight - pop) < BUF_DEPTH, where pop = M_VALID_o && M_READY_i in the same cycle.
  - FIFO_REN_o is combinational from registered state plus FIFO_EMPTY_i and M_READY_i.
- In-flight tracking:
  - A shift register of RD_LAT bits marks which cycles return data.
  - Data is written into the buffer tail on the cycle the marker exits the shift register.
  - inflight = popcount of the shift register.
- Buffer:
  - Circular, BUF_DEPTH entries, with head and tail pointers that wrap modulo BUF_DEPTH.
  - Push and pop in the same cycle leave count unchanged. Push when full cannot occur because the credit rule prevents it; assert this in simulation.
- Stream:
  - M_VALID_o = (count != 0).
  - M_DATA_o = buffer[head].
  - M_DATA_o is stable while M_VALID_o=1 and M_READY_i=0.
  - Data is never presented combinationally from FIFO_RDATA_i, so first data appears at least RD_LAT+1 cycles after FIFO_REN_o.
- Throughput: with FIFO non-empty and M_READY_i held at 1, one word transfers per cycle in steady state.
- Flush:
  - When FLUSH_i is sampled at 1: count, head, tail and the in-flight shift register all clear on the next edge, and M_VALID_o=0 from that cycle.
  - FIFO_REN_o is forced to 0 during FLUSH.
  - Data returned for reads issued before the flush is discarded.
  - FLUSH_i held high keeps the block in FLUSH.
- Error:
  - ERR_o sets when FIFO_UNDERRUN_i=1 in RUN.
  - ERR_o clears only on reset or flush.
- EMPTY timing: FIFO_EMPTY_i asserts in the cycle after the REN that consumes the last word. The REN rule permits at most one read per cycle, so the adapter never over-reads.

Optional Feature:
- Macro FIFO_RD_STREAM_STATS_EN.
- Defined:
  - Adds output WORD_CNT_o (32-bit): increments on each M_VALID_o&&M_READY_i, wraps at 2^32, resets to 0 on RST_ni and on flush.
  - Adds output STALL_CNT_o (16-bit): counts cycles with M_VALID_o=1 and M_READY_i=0, and saturates at 16'hFFFF.
- Undefined: neither port exists and no counter logic is generated.

Test Plan:
- Reset then idle: release RST_ni with FIFO_EMPTY_i=1 -> FIFO_FLUSH_no low 2 cycles then high; FIFO_REN_o=0, M_VALID_o=0 throughout.
- Streaming: FIFO model holds 8 words 0x00001..0x00008, M_READY_i=1 -> FIFO_REN_o high 8 consecutive cycles; M_VALID_o high 8 consecutive cycles carrying 1..8 in order; first beat 2 cycles after first REN (RD_LAT=1).
- Backpressure: 8 words queued, M_READY_i=0 -> exactly 2 REN pulses; M_DATA_o=0x00001 held stable; after M_READY_i=1, all 8 words delivered in order with no loss or duplication.
- Empty boundary: 1 word in FIFO -> single REN; FIFO_EMPTY_i=1 next cycle; no further REN; one beat 0x00001 delivered.
- Flush with data in flight: assert FLUSH_i in the cycle after a REN -> returning word discarded; M_VALID_o=0 next cycle; FIFO_FLUSH_no low 2 cycles; then normal reads resume.
- Underrun: pulse FIFO_UNDERRUN_i in RUN -> ERR_o=1 and stays 1 until FLUSH_i; with FIFO_RD_STREAM_STATS_EN, after test 2 WORD_CNT_o=8.
